// File: rtl/relu_maxpool_out.sv
// ReLU + 2x2/stride-2 max-pool over a coordinate-tagged stream, results queued in a small FIFO.
// Latency: 1 cycle from 4th window sample to pool_valid; a full FIFO with no pop drops the result and sets overflow.
module relu_maxpool_out #(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int FIFO_DEPTH         = 4,
    localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
    localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
    localparam int CW  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
    localparam int PXW = (XW > 1) ? XW - 1 : 1,
    localparam int PYW = (YW > 1) ? YW - 1 : 1
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic [XW-1:0]                in_x,
    input  logic [YW-1:0]                in_y,
    input  logic [CW-1:0]                in_ch,
    output logic [DATA_WIDTH-1:0]        pool_data,
    output logic                         pool_valid,
    input  logic                         pool_ready,
    output logic [PXW-1:0]               pool_x,
    output logic [PYW-1:0]               pool_y,
    output logic [CW-1:0]                pool_ch,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overflow
);
    localparam int NENT  = (FEATURE_MAP_WIDTH / 2) * OUTPUT_NB_CHANNELS;
    localparam int EW    = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int TOTAL = (FEATURE_MAP_WIDTH / 2) * (FEATURE_MAP_HEIGHT / 2) * OUTPUT_NB_CHANNELS;
    localparam int ECW   = $clog2(TOTAL + 1);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [PXW-1:0]        x;
        logic [PYW-1:0]        y;
        logic [CW-1:0]         ch;
    } res_t;

    logic signed [DATA_WIDTH-1:0] r_max [NENT];
    logic [1:0]                   r_cnt [NENT];
    logic [ECW-1:0]               r_emit;
    logic                         r_busy;
    logic                         r_frame_done;
    logic                         r_overflow;
    res_t                         r_mem [FIFO_DEPTH];
    logic [AW-1:0]                r_wp;
    logic [AW-1:0]                r_rp;
    logic [AW:0]                  r_fcnt;

    logic [EW-1:0]                w_idx;
    logic [1:0]                   w_cnt;
    logic signed [DATA_WIDTH-1:0] w_max_old;
    logic signed [DATA_WIDTH-1:0] w_max_new;
    logic                         w_push;
    logic                         w_full;
    logic                         w_pop;
    logic                         w_wr;
    res_t                         w_res;

    assign w_idx     = EW'(32'(in_x >> 1) * OUTPUT_NB_CHANNELS + 32'(in_ch));
    // A sample arriving with start sees the cleared store, so it is a first arrival.
    assign w_cnt     = start ? 2'd0 : r_cnt[w_idx];
    assign w_max_old = r_max[w_idx];
    assign w_max_new = (w_cnt == 2'd0 || in_data > w_max_old) ? in_data : w_max_old;
    assign w_push    = in_valid && (w_cnt == 2'd3);

    assign w_res.data = w_max_new[DATA_WIDTH-1] ? '0 : w_max_new;
    assign w_res.x    = PXW'(in_x >> 1);
    assign w_res.y    = PYW'(in_y >> 1);
    assign w_res.ch   = in_ch;

    assign w_full = (r_fcnt == (AW+1)'(FIFO_DEPTH));
    assign w_pop  = (r_fcnt != '0) && pool_ready;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < NENT; i++) r_cnt[i] <= 2'd0;
        end else begin
            if (start) begin
                for (int i = 0; i < NENT; i++) r_cnt[i] <= 2'd0;
            end
            if (in_valid) r_cnt[w_idx] <= w_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) r_max[w_idx] <= w_max_new;
    end

    // Dropped results still advance the emit count so frame_done stays aligned to the frame.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_emit       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (start) begin
                r_emit <= '0;
                r_busy <= 1'b1;
            end else if (w_push) begin
                if (r_emit == ECW'(TOTAL - 1)) begin
                    r_emit       <= '0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_emit <= r_emit + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_fcnt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= w_res;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign pool_data  = r_mem[r_rp].data;
    assign pool_x     = r_mem[r_rp].x;
    assign pool_y     = r_mem[r_rp].y;
    assign pool_ch    = r_mem[r_rp].ch;
    assign pool_valid = (r_fcnt != '0);
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_relu_maxpool_out.sv
// Directed bench for relu_maxpool_out on a 4x4x2 map: scoreboard queue checked at every output handshake.
module tb_relu_maxpool_out;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic [1:0]           in_x = '0;
    logic [1:0]           in_y = '0;
    logic [0:0]           in_ch = '0;
    logic                 pool_ready = 1'b0;
    logic [DW-1:0]        pool_data;
    logic                 pool_valid;
    logic [0:0]           pool_x, pool_y, pool_ch;
    logic                 busy, frame_done, overflow;

    int errors = 0;
    int checks = 0;
    logic [DW+2:0] sb [$];
    logic [DW+2:0] mon_exp;
    int frame_tbl [8][4] = '{'{5, -3, 9, 2}, '{-7, -2, -9, -4}, '{-32768, 32767, 0, -1},
                             '{1, 2, 3, 4}, '{100, -100, 50, 25}, '{-1, -1, -1, -1},
                             '{0, 0, 0, 0}, '{300, 301, 299, -300}};

    relu_maxpool_out #(
        .DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
        .OUTPUT_NB_CHANNELS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .pool_data(pool_data), .pool_valid(pool_valid),
        .pool_ready(pool_ready), .pool_x(pool_x), .pool_y(pool_y), .pool_ch(pool_ch),
        .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pool_of(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 0) m = 0;
        return DW'(m);
    endfunction

    task automatic send(input int x, input int y, input int ch, input int d);
        in_x     = 2'(x);
        in_y     = 2'(y);
        in_ch    = 1'(ch);
        in_data  = DW'(d);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic win4(input int px, input int py, input int ch,
                        input int a, input int b, input int c, input int d, input bit keep);
        send(2*px,   2*py,   ch, a);
        send(2*px+1, 2*py,   ch, b);
        send(2*px,   2*py+1, ch, c);
        if (keep) sb.push_back({pool_of(a, b, c, d), 1'(px), 1'(py), 1'(ch)});
        send(2*px+1, 2*py+1, ch, d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (arst_n && pool_valid && pool_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output: observed=%0h expected=none",
                       {pool_data, pool_x, pool_y, pool_ch});
            end else begin
                mon_exp = sb.pop_front();
                checks++;
                assert ({pool_data, pool_x, pool_y, pool_ch} === mon_exp) else begin
                    errors++;
                    $error("FAIL pool_result: observed=%0h expected=%0h",
                           {pool_data, pool_x, pool_y, pool_ch}, mon_exp);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles with a valid sample present.
        arst_n = 1'b0; in_valid = 1'b1; in_data = 16'sd123; pool_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(pool_valid), 32'd0);
        check("reset_data", 32'(pool_data), 32'd0);
        check("reset_xyc", 32'({pool_x, pool_y, pool_ch}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b0; arst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_push_after_reset", 32'(pool_valid), 32'd0);

        // Full frame of 8 windows.
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            win4((i / 2) % 2, i / 4, i % 2, frame_tbl[i][0], frame_tbl[i][1],
                 frame_tbl[i][2], frame_tbl[i][3], 1'b1);
            if (i == 0) check("latency_valid", 32'(pool_valid), 32'd1);
            if (i == 6) check("no_early_done", 32'(frame_done), 32'd0);
        end
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("busy_cleared", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("frame_done_one_cycle", 32'(frame_done), 32'd0);
        drain("drain_frame");

        // Interleaved channels, ch1's last corner arrives first.
        pulse_start();
        send(1, 1, 1, 10);
        send(0, 0, 0, -1);
        send(0, 0, 1, 3);
        send(1, 0, 0, 4);
        send(1, 0, 1, -5);
        send(0, 1, 0, 7);
        sb.push_back({16'd7, 1'b0, 1'b0, 1'b0});
        send(1, 1, 0, 2);
        sb.push_back({16'd10, 1'b0, 1'b0, 1'b1});
        send(0, 1, 1, 6);
        drain("drain_interleave");

        // Fill FIFO, hold, then push and pop together on full.
        pool_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) win4(i / 2, 0, i % 2, i, 20 + i, -i, 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_stable", 32'({pool_data, pool_x, pool_y, pool_ch}), 32'(sb[0]));
        end
        @(posedge clk);
        #1;
        send(0, 2, 0, -8);
        send(1, 2, 0, 44);
        send(0, 3, 0, 12);
        sb.push_back({16'd44, 1'b0, 1'b1, 1'b0});
        pool_ready = 1'b1;
        send(1, 3, 0, 1);
        check("full_push_pop_no_ovf", 32'(overflow), 32'd0);
        drain("drain_push_pop");
        check("empty_after_drain", 32'(pool_valid), 32'd0);

        // Overflow: fifth result dropped.
        pool_ready = 1'b0;
        for (int i = 0; i < 4; i++) win4(i / 2, 1, i % 2, 50 + i, 1, 2, 3, 1'b1);
        win4(1, 1, 0, 99, 98, 97, 96, 1'b0);
        check("overflow_set", 32'(overflow), 32'd1);
        pool_ready = 1'b1;
        drain("drain_overflow");
        check("empty_after_ovf_drain", 32'(pool_valid), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);
        pulse_start();
        check("overflow_survives_start", 32'(overflow), 32'd1);

        // Start mid-frame clears partial windows and the emit count.
        win4(1, 1, 1, 8, 9, 10, 11, 1'b1);
        send(0, 0, 0, 100);
        send(1, 0, 0, 200);
        pulse_start();
        win4(0, 0, 0, 1, 2, 3, 4, 1'b1);
        for (int j = 1; j < 8; j++) begin
            win4((j / 2) % 2, j / 4, j % 2, j, -j, 2 * j, 0, 1'b1);
            if (j == 6) check("done_not_after_7", 32'(frame_done), 32'd0);
        end
        check("done_after_8_restart", 32'(frame_done), 32'd1);
        drain("drain_restart");

        // Reset mid-window discards partial state and clears overflow.
        send(0, 0, 0, 500);
        send(1, 0, 0, 600);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        check("ovf_cleared_by_reset", 32'(overflow), 32'd0);
        win4(0, 0, 0, 1, 1, 1, 1, 1'b1);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/relu_maxpool_out.md
# relu_maxpool_out

Streaming post-processing stage directly downstream of the convolution core's output port. It consumes the core's coordinate-tagged output stream (data, x, y, channel, valid; no backpressure), applies ReLU and 2×2/stride-2 max-pooling per channel, and presents pooled results on a valid/ready stream through a small output FIFO. Pooling windows are tracked per entry, so any arrival order of the four window elements is accepted.

## Interface
- DATA_WIDTH, 16: signed sample width.
- FEATURE_MAP_WIDTH, 128: input map width W; must be even.
- FEATURE_MAP_HEIGHT, 128: input map height H; must be even.
- OUTPUT_NB_CHANNELS, 32: channel count C.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on posedge.
- arst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a new frame.
- in_data  in  DATA_WIDTH  signed conv output sample.
- in_valid  in  1  sample valid; no ready, never stalled.
- in_x  in  clog2(W)  sample column.
- in_y  in  clog2(H)  sample row.
- in_ch  in  clog2(C)  sample channel.
- pool_data  out  DATA_WIDTH  pooled, ReLU'd result (always ≥0).
- pool_valid  out  1  FIFO head valid.
- pool_ready  in  1  consumer accepts head.
- pool_x  out  clog2(W)-1  pooled column = in_x>>1.
- pool_y  out  clog2(H)-1  pooled row = in_y>>1.
- pool_ch  out  clog2(C)  channel.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when last pooled result of the frame enters the FIFO.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- Window store: (W/2)·C entries, index = (in_x>>1)·C + in_ch; each entry holds running max (DATA_WIDTH, signed) and a 2-bit arrival count.
- Per accepted sample (in_valid=1): read entry combinationally, same-cycle write back.
  - count==0: max←in_data, count←1.
  - count 1 or 2: max←signed max(max, in_data), count+1.
  - count==3: result = max(max, in_data), clamped to 0 if negative; push {result, x>>1, y>>1, ch} into FIFO; count←0 (entry reused for next pooled row).
- Rows y and y^1 of a window must complete before row pair y+2 reuses the entry; the upstream core's raster order guarantees this; not checked.
- Emit counter counts pushes (including dropped ones); when it reaches (W/2)(H/2)C−1 and a push occurs: frame_done pulses, busy←0, counter←0.
- start: clears all counts and the emit counter, busy←1. A sample presented in the start cycle is processed against the cleared state (counts as first arrival). overflow is not cleared by start.
- in_valid while busy=0: sample still processed (no gating); frame_done accounting unchanged.
- FIFO: push on window completion; pop when pool_valid&&pool_ready. Push and pop in the same cycle on a full FIFO: both succeed, no overflow. Push on full without pop: result dropped, overflow←1.

## Timing
- Reset (arst_n=0 at posedge): all counts 0, FIFO empty, emit counter 0; pool_valid=0, pool_data/x/y/ch=0, busy=0, frame_done=0, overflow=0. Reset mid-frame discards partial windows and FIFO contents.
- Latency: 4th window sample captured at edge N → pool_valid=1 after edge N (visible the following cycle) if FIFO was empty.
- Throughput: one input per cycle sustained; one pop per cycle.
- Outputs registered from FIFO storage; pool_data/x/y/ch stable while pool_valid&&!pool_ready.
- frame_done asserted the cycle after the final push edge, for exactly one cycle.

## Test plan
- Reset: hold arst_n=0 two cycles with in_valid=1 → all outputs 0, no pushes.
- Single window, W=H=2, C=1, pool_ready=1: start, samples 5, −3, 9, 2 at (0,0),(1,0),(0,1),(1,1) → one result pool_data=9, x=y=ch=0, one cycle after last sample; frame_done pulses; busy→0.
- ReLU: window samples −7, −2, −9, −4 → pool_data=0; extreme −32768 and 32767 in one window → 32767.
- Out-of-order/interleaved: C=2, four samples of ch1 and ch0 interleaved, ch1's (1,1) arriving first → ch1 result = its max, ch0 result independent, order of results = order of window completion.
- Backpressure/overflow: pool_ready=0, complete FIFO_DEPTH+1 windows → first 4 retained in order, overflow=1 sticky; then pool_ready=1 drains 4 then pool_valid=0; full-FIFO push+pop same cycle → no overflow.
- start mid-frame: two samples into a window, start pulse, then four fresh samples → result reflects only the fresh four; emit count restarted.
